// File: rtl/ns_prio_dec.sv
// ns_prio_dec: rebuilds a WIDTH-bit vector from a stream of bit indices sent
// highest-first (inverse of a repeated MSB priority encoder). One vector is
// emitted per packet over a valid/ready output. Ordering violations, bad
// indices and misplaced null beats are flagged on out_err.
//
// The control state is implicit in two flags:
//   IDLE  : first_q = 1 (no beat accepted yet in the current packet)
//   ACCUM : first_q = 0 (packet in progress)
//   HOLD  : out_vld_q = 1 (result waiting for downstream)
// ACCUM and HOLD overlap, so a new packet can build up while the previous
// result is still waiting.
module ns_prio_dec #(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned IW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [IW-1:0]    in_idx,
    input  logic             in_null,
    input  logic             in_last,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_vec,
    output logic             out_err
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [IW-1:0]    prev_q, prev_d;
    logic             first_q, first_d;
    logic             err_acc_q, err_acc_d;
    logic [WIDTH-1:0] out_vec_q, out_vec_d;
    logic             out_err_q, out_err_d;
    logic             out_vld_q, out_vld_d;

    logic [WIDTH-1:0] beat_bit;
    logic             beat_err;
    logic             idx_oob;
    logic             in_fire;

    // Only a last beat needs the output register, so only it can stall.
    assign in_rdy  = !out_vld_q | out_rdy | !in_last;
    assign in_fire = in_vld & in_rdy;

    assign out_vld = out_vld_q;
    assign out_vec = out_vec_q;
    assign out_err = out_err_q;

    // Decode the current beat into its bit contribution and its own error.
    always_comb begin
        beat_bit = '0;
        beat_err = 1'b0;
        idx_oob  = 32'(in_idx) >= WIDTH;
        if (in_null) begin
            // A null beat is only legal as a packet of its own.
            beat_err = !first_q;
        end else begin
            // An out-of-range index shifts the bit out, so it sets nothing.
            beat_bit = WIDTH'(1) << in_idx;
            beat_err = idx_oob | (!first_q & (in_idx >= prev_q));
        end
    end

    // Next state: accumulate beats, hand the result to the output register on
    // the last beat, and drain the output on the downstream handshake.
    always_comb begin
        acc_d     = acc_q;
        prev_d    = prev_q;
        first_d   = first_q;
        err_acc_d = err_acc_q;
        out_vec_d = out_vec_q;
        out_err_d = out_err_q;
        out_vld_d = out_vld_q;

        if (out_vld_q && out_rdy) begin
            out_vld_d = 1'b0;
        end

        if (in_fire) begin
            if (in_last) begin
                // A reload in the same cycle as a drain keeps out_vld high.
                out_vec_d = acc_q | beat_bit;
                out_err_d = err_acc_q | beat_err;
                out_vld_d = 1'b1;
                acc_d     = '0;
                err_acc_d = 1'b0;
                prev_d    = '0;
                first_d   = 1'b1;
            end else begin
                acc_d     = acc_q | beat_bit;
                err_acc_d = err_acc_q | beat_err;
                first_d   = 1'b0;
                if (!in_null) begin
                    prev_d = in_idx;
                end
            end
        end
    end

    // State registers; reset discards any partial packet and held output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            prev_q    <= '0;
            first_q   <= 1'b1;
            err_acc_q <= 1'b0;
            out_vec_q <= '0;
            out_err_q <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            prev_q    <= prev_d;
            first_q   <= first_d;
            err_acc_q <= err_acc_d;
            out_vec_q <= out_vec_d;
            out_err_q <= out_err_d;
            out_vld_q <= out_vld_d;
        end
    end

endmodule

// File: doc/ns_prio_dec.md
# ns_prio_dec

Stream-to-vector priority decoder. It is the inverse of `ns_prio_enc`: it rebuilds a WIDTH-bit request vector from a stream of encoded bit indices, sent highest index first, one index per beat. It sits on the receive side of a link that serialises vectors by repeated MSB priority encoding. It delivers one reconstructed vector per packet over a valid/ready handshake and flags ordering violations.

## Interface
- `WIDTH`, 8, vector width, ≥2; `IW = $clog2(WIDTH)` is a local derived width.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_vld` input 1: input beat valid.
- `in_rdy` output 1: input beat accepted when `in_vld & in_rdy`.
- `in_idx` input IW: bit index carried by the beat.
- `in_null` input 1: beat carries no index and `in_idx` is ignored. Used to send an all-zero vector.
- `in_last` input 1: final beat of the packet.
- `out_vld` output 1: reconstructed vector valid.
- `out_rdy` input 1: downstream accepts when `out_vld & out_rdy`.
- `out_vec` output WIDTH: reconstructed vector.
- `out_err` output 1: packet violated the ordering rules. Qualified by `out_vld`.

## Operation
- Internal state:
  - accumulator `acc[WIDTH]`
  - previous index `prev[IW]`
  - `first` flag (1 = no beat yet accepted in the current packet)
  - sticky `err_acc`
  - output register holding `out_vec`, `out_err`, `out_vld`
- FSM, derived from `first` and `out_vld`:
  - **IDLE**: `first=1`, accumulating nothing.
  - **ACCUM**: `first=0`, packet in progress.
  - **HOLD**: `out_vld=1`, output waiting for downstream.
  - ACCUM and HOLD may coexist: a new packet can accumulate while the previous result waits.
- `in_rdy = !out_vld | out_rdy | !in_last`. A non-last beat is always accepted. A last beat stalls only while the output is occupied and not draining.
- Accepted beat, no `in_null`:
  - Set `acc[in_idx]`. If `in_idx ≥ WIDTH`, set no bit and set `err_acc`.
  - If `!first` and `in_idx ≥ prev`, set `err_acc`. Indices must be strictly descending.
  - Then `prev <= in_idx`, `first <= 0`.
- Accepted beat with `in_null`:
  - Contributes no bit.
  - If `!first`, set `err_acc`. A null beat is legal only as a one-beat packet.
- Accepted beat with `in_last`:
  - `out_vec <= acc | decoded bit of this beat`.
  - `out_err <= err_acc | error of this beat`.
  - `out_vld <= 1`.
  - Clear `acc`, `err_acc`, `prev`; set `first <= 1`.
- Output handshake:
  - `out_vld` falls on `out_vld & out_rdy` unless a new last beat is accepted in the same cycle. In that case the output register reloads and `out_vld` stays 1.
  - `out_vec` and `out_err` stay stable while `out_vld & !out_rdy`.
- Beats with `in_vld=0` change nothing. `in_*` are don't-care when `in_vld=0`.

## Timing
- Reset values while `rst=1` (asynchronous):
  - `out_vld=0`, `out_vec=0`, `out_err=0`
  - `acc=0`, `err_acc=0`, `prev=0`, `first=1`
  - `in_rdy` is 1 (combinational from the reset state).
- Latency: `out_vld` rises on the clock edge that accepts the last beat. The vector is visible in the cycle after acceptance.
- Throughput: one beat per cycle. A one-beat packet every cycle is sustained while `out_rdy=1`.
- Back-pressure:
  - A last beat with `out_vld=1` and `out_rdy=0` is held: `in_rdy=0` and `acc` is unchanged.
  - The packet completes on the first cycle `out_rdy=1`.
- Reset mid-packet discards the partial `acc` and any held output. There is no partial output after reset.
- `in_rdy` depends combinationally on `out_rdy` and `in_last`. There is no combinational path from `in_vld` to `in_rdy`.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle during ACCUM with `acc=8'h80`. Required: all outputs 0 immediately. A following packet {3, last} gives `out_vec=8'h08`, `out_err=0`.
- **Multi-beat packet:** beats 7, 4, 1 (last 1), `out_rdy=1`. Required: `out_vld` for exactly one cycle after the third beat, `out_vec=8'h92`, `out_err=0`.
- **Ordering violation:** beats 2, 5 (last). Required: `out_vec=8'h24`, `out_err=1`. Then a duplicate-index packet 6, 6 (last) gives `out_vec=8'h40`, `out_err=1`.
- **Null packet:** a single null+last beat gives `out_vec=8'h00`, `out_err=0`. A packet 3 then null+last gives `out_vec=8'h08`, `out_err=1`.
- **Back-pressure:** `out_rdy=0`; packet {5, last} then packet {6, 0 (last)}.
  - Required: `out_vec=8'h20` held stable.
  - Beat 6 is accepted; the last beat 0 sees `in_rdy=0` until `out_rdy=1`.
  - Then `8'h20` is taken and `8'h41` follows with no lost or duplicated vectors.
- **Randomised:** random vectors are serialised by an `ns_prio_enc` reference model with random `in_vld`/`out_rdy` gaps for 10k packets. Required: every `out_vec` equals its source vector and `out_err` is always 0.
